// File: rtl/trng_harvester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trng_harvester
// Purpose  : Sampled raw entropy -> von Neumann corrector -> OUT_W-bit words
//            -> show-ahead FIFO with valid/ready drain. Optional repetition
//            count health test built when TRNG_HEALTH_EN is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module trng_harvester #(
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_LIMIT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          raw_entropy_in,
  input  logic                          enable,
  output logic [OUT_W-1:0]              rnd_data,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int c_BW = $clog2(OUT_W);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2;
  logic [c_DW-1:0]      r_div;
  logic                 r_a;
  logic [OUT_W-1:0]     r_shift;
  logic [OUT_W-1:0]     r_hold;
  logic [c_BW-1:0]      r_bitcnt;
  logic [OUT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]        r_level;
  logic                 r_valid;

  logic                 w_strobe, w_full, w_pop, w_push, w_trip, w_halt;
  logic [c_AW:0]        w_level_nxt;

  assign w_strobe    = enable && (r_div == c_DW'(SAMPLE_DIV - 1));
  assign w_full      = (r_level == (c_AW+1)'(FIFO_DEPTH));
  assign w_pop       = r_valid && rnd_ready;
  assign w_push      = (r_state == STALL) && enable && !w_halt && (!w_full || w_pop);
  assign w_level_nxt = r_level + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_entropy_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_div <= '0;
    else if (!enable || w_strobe)
      r_div <= '0;
    else
      r_div <= r_div + 1'b1;
  end

`ifdef TRNG_HEALTH_EN
  localparam int c_CW = $clog2(RCT_LIMIT + 1);
  logic            r_fail;
  logic            r_rct_val;
  logic [c_CW-1:0] r_rct_cnt;

  assign w_trip = w_strobe && !r_fail && (r_sync2 == r_rct_val) &&
                  (r_rct_cnt == c_CW'(RCT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail    <= 1'b0;
      r_rct_val <= 1'b0;
      r_rct_cnt <= '0;
    end else if (!enable) begin
      r_fail    <= 1'b0;
      r_rct_cnt <= '0;
    end else if (w_strobe && !r_fail) begin
      // a zero count means no reference sample yet
      if (r_rct_cnt != '0 && r_sync2 == r_rct_val) begin
        r_rct_cnt <= r_rct_cnt + 1'b1;
      end else begin
        r_rct_val <= r_sync2;
        r_rct_cnt <= c_CW'(1);
      end
      if (w_trip)
        r_fail <= 1'b1;
    end
  end

  assign w_halt      = r_fail || w_trip;
  assign health_fail = r_fail;
`else
  assign w_trip      = 1'b0;
  assign w_halt      = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FIRST;
      r_a      <= 1'b0;
      r_shift  <= '0;
      r_hold   <= '0;
      r_bitcnt <= '0;
    end else if (!enable || w_halt) begin
      r_state  <= FIRST;
      r_a      <= 1'b0;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        FIRST: begin
          if (w_strobe) begin
            r_a     <= r_sync2;
            r_state <= SECOND;
          end
        end
        SECOND: begin
          if (w_strobe) begin
            r_state <= FIRST;
            if (r_sync2 != r_a) begin
              r_shift <= {r_shift[OUT_W-2:0], r_a};
              if (r_bitcnt == c_BW'(OUT_W - 1)) begin
                r_hold   <= {r_shift[OUT_W-2:0], r_a};
                r_bitcnt <= '0;
                r_state  <= STALL;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
        end
        // a finished word waits here until the FIFO can take it
        STALL: begin
          if (w_push)
            r_state <= FIRST;
        end
        default: r_state <= FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else if (w_trip) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_hold;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign rnd_data   = r_mem[r_rd_ptr];
  assign rnd_valid  = r_valid;
  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_trng_harvester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_trng_harvester
// Purpose  : Directed and randomised checks of trng_harvester against a
//            sample-list reference model (pairs -> bits -> words -> queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_harvester;
  localparam int OUT_W = 32;
  localparam int DIV   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        raw = 1'b0;
  logic        enable = 1'b0;
  logic        rnd_ready = 1'b0;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic [2:0]  fifo_level;
  logic        health_fail;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q_exp[$];
  bit          m_have_a, m_a;
  logic [31:0] m_word;
  int          m_bits, m_words;
  bit          rand_rdy;
  int          run_len;
  bit          last_s;

  trng_harvester #(.OUT_W(32), .FIFO_DEPTH(4), .SAMPLE_DIV(DIV), .RCT_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .raw_entropy_in(raw), .enable(enable),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .fifo_level(fifo_level), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // one clock; any pop occurring on this edge is checked against the model
  task automatic tick();
    logic [31:0] e;
    if (rand_rdy) rnd_ready = 1'($urandom_range(0, 1));
    if (rnd_valid && rnd_ready) begin
      e = (q_exp.size() != 0) ? q_exp.pop_front() : 32'hxxxxxxxx;
      check("pop_data", rnd_data, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_have_a = 0; m_bits = 0; m_word = '0;
  endtask

  // one strobe period holding raw at b; the model sees the sample after it
  task automatic feed(input bit b, input bit mdl);
    raw = b;
    repeat (DIV) tick();
    if (mdl) begin
      if (!m_have_a) begin
        m_a = b; m_have_a = 1;
      end else begin
        m_have_a = 0;
        if (m_a != b) begin
          m_word = {m_word[30:0], m_a};
          m_bits++;
          if (m_bits == OUT_W) begin
            q_exp.push_back(m_word);
            m_bits = 0;
            m_words++;
          end
        end
      end
    end
  endtask

  function automatic bit rnd_bit();
    bit b;
    b = 1'($urandom_range(0, 1));
    if (run_len >= 5 && b == last_s) b = ~last_s;
    run_len = (b == last_s) ? run_len + 1 : 1;
    last_s  = b;
    return b;
  endfunction

  task automatic feed_word();
    int w0 = m_words;
    int n = 0;
    while (m_words == w0 && n < 4000) begin
      feed(rnd_bit(), 1);
      n++;
    end
    check("feed_word_done", m_words, w0 + 1);
  endtask

  // re-aligns divider phase with the bench and drops any partial word
  task automatic restart();
    enable = 1'b0;
    tick();
    model_clear();
    enable = 1'b1;
  endtask

  initial begin
    model_clear();
    m_words = 0; rand_rdy = 0; run_len = 0; last_s = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_data",   rnd_data,    0);
    check("rst_valid",  rnd_valid,   0);
    check("rst_level",  fifo_level,  0);
    check("rst_health", health_fail, 0);
    rst = 1'b0;
    tick();

    // (0,1) x32 -> all-zero word
    restart();
    repeat (32) begin feed(0, 1); feed(1, 1); end
    check("t1_valid_pre", rnd_valid, 0);
    tick();
    check("t1_valid", rnd_valid, 1);
    check("t1_level", fifo_level, 1);
    check("t1_data",  rnd_data, 32'h0000_0000);
    rnd_ready = 1; tick(); rnd_ready = 0;
    check("t1_drained", fifo_level, 0);

    // (1,0) x16 then (0,1) x16
    restart();
    repeat (16) begin feed(1, 1); feed(0, 1); end
    repeat (16) begin feed(0, 1); feed(1, 1); end
    tick();
    check("t2_data", rnd_data, 32'hFFFF_0000);
    rnd_ready = 1; tick(); rnd_ready = 0;

    // equal pairs interleaved with (1,0)
    restart();
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) begin feed(1, 1); feed(1, 1); end
      else begin feed(0, 1); feed(0, 1); end
      feed(1, 1); feed(0, 1);
    end
    tick();
    check("t3_data",  rnd_data, 32'hFFFF_FFFF);
    check("t3_level", fifo_level, 1);
    rnd_ready = 1; tick(); rnd_ready = 0;
    check("t3_drained", fifo_level, 0);

    // back-pressure: 5 words into a 4-deep FIFO
    restart();
    repeat (5) feed_word();
    tick(); tick();
    check("t4_full_level", fifo_level, 4);
    check("t4_full_valid", rnd_valid, 1);
    rnd_ready = 1; tick(); rnd_ready = 0;
    check("t4_level_after_pop", fifo_level, 4);
    rnd_ready = 1; repeat (6) tick(); rnd_ready = 0;
    check("t4_drained", fifo_level, 0);
    check("t4_all_words_seen", q_exp.size(), 0);

    // partial word discarded on enable drop
    restart();
    repeat (10) begin feed(1, 1); feed(0, 1); end
    restart();
    repeat (16) begin feed(1, 1); feed(0, 1); feed(0, 1); feed(1, 1); end
    tick();
    check("t5_data", rnd_data, 32'hAAAA_AAAA);
    restart();
    repeat (2) feed_word();
    tick();
    check("t5_level3", fifo_level, 3);
    rst = 1'b1; #1;
    check("t5_rst_data",  rnd_data,   0);
    check("t5_rst_valid", rnd_valid,  0);
    check("t5_rst_level", fifo_level, 0);
    q_exp.delete();
    model_clear();
    rst = 1'b0;
    tick();

    // random data, random consumer
    restart();
    rand_rdy = 1;
    repeat (4) feed_word();
    rand_rdy = 0; rnd_ready = 1;
    repeat (4) tick();
    rnd_ready = 0;
    check("t6_drained", fifo_level, 0);
    check("t6_all_words_seen", q_exp.size(), 0);

`ifdef TRNG_HEALTH_EN
    restart();
    repeat (2) feed_word();
    feed(0, 1);
    check("t7_level2", fifo_level, 2);
    repeat (15) feed(1, 0);
    check("t7_health_pre", health_fail, 0);
    feed(1, 0);
    check("t7_health_set", health_fail, 1);
    check("t7_flush_level", fifo_level, 0);
    check("t7_flush_valid", rnd_valid, 0);
    q_exp.delete();
    repeat (32) begin feed(0, 0); feed(1, 0); end
    tick();
    check("t7_halted_level", fifo_level, 0);
    restart();
    tick();
    check("t7_health_clear", health_fail, 0);
`else
    restart();
    repeat (20) feed(1, 0);
    check("t7_health_tied", health_fail, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
